// File: rtl/cpu_pc_pkg.sv
// Shared CPU constants: request priority encoding and default return-stack depth.
package cpu_pc_pkg;

  localparam int DEFAULT_STACK_DEPTH = 4;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_JMP  = 2'd1,
    REQ_CALL = 2'd2,
    REQ_RET  = 2'd3
  } req_e;

  // RET beats CALL beats JMP; losers are simply dropped.
  function automatic req_e decode_req(input logic jmp, input logic call, input logic ret);
    if (ret) begin
      return REQ_RET;
    end else if (call) begin
      return REQ_CALL;
    end else if (jmp) begin
      return REQ_JMP;
    end
    return REQ_NONE;
  endfunction

endpackage

// File: rtl/cpu_pc_if.sv
// Program-counter control bus: requests from the sequencer, PC and stack status back.
interface cpu_pc_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             jmp;
  logic [WIDTH-1:0] jmp_addr;
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] pc_out;
  logic             stack_empty;
  logic             stack_full;
  logic             stack_err;

  modport master (
    output en, jmp, jmp_addr, call, ret,
    input  pc_out, stack_empty, stack_full, stack_err
  );

  modport slave (
    input  en, jmp, jmp_addr, call, ret,
    output pc_out, stack_empty, stack_full, stack_err
  );
endinterface

// File: rtl/alu_add.sv
// Generic ripple adder with carry in/out, shared by the datapath and the PC.
module alu_add #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
endmodule

// File: rtl/cpu_ras.sv
// Return-address stack: LIFO of DEPTH entries, count-based flags, entries not reset.
module cpu_ras #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    cnt_q;
  logic [PW-1:0]    wr_ptr;

  assign wr_ptr = cnt_q[PW-1:0];
  // Low count bits minus one wraps to DEPTH-1 when full, so top is always the last push.
  assign top    = mem[wr_ptr - PW'(1)];
  assign empty  = (cnt_q == CW'(0));
  assign full   = (cnt_q == CW'(DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (push && !full) begin
      cnt_q <= cnt_q + CW'(1);
    end else if (pop && !empty) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push && !full) begin
      mem[wr_ptr] <= din;
    end
  end
endmodule

// File: rtl/cpu_pc.sv
// Program counter with jump/call/return and a sticky-error return-address stack.
module cpu_pc
  import cpu_pc_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int STACK_DEPTH = DEFAULT_STACK_DEPTH
) (
  input logic        CLK,
  input logic        RST,
  cpu_pc_if.slave    bus
);
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_nxt;
  logic [WIDTH-1:0] pc_inc;
  logic             inc_cout_unused;
  logic             err_q;
  logic             err_nxt;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] ras_top;
  logic             ras_empty;
  logic             ras_full;
  req_e             req;

  alu_add #(.WIDTH(WIDTH)) u_inc (
    .a    (pc_q),
    .b    ({WIDTH{1'b0}}),
    .cin  (1'b1),
    .sum  (pc_inc),
    .cout (inc_cout_unused)
  );

  cpu_ras #(.WIDTH(WIDTH), .DEPTH(STACK_DEPTH)) u_ras (
    .clk   (CLK),
    .rst   (RST),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .top   (ras_top),
    .empty (ras_empty),
    .full  (ras_full)
  );

  assign req = decode_req(bus.jmp, bus.call, bus.ret);

  // Overflowing CALL and underflowing RET degrade to a plain increment and flag the error.
  always_comb begin
    push    = 1'b0;
    pop     = 1'b0;
    pc_nxt  = pc_q;
    err_nxt = err_q;
    if (bus.en) begin
      pc_nxt = pc_inc;
      unique case (req)
        REQ_RET: begin
          if (!ras_empty) begin
            pop    = 1'b1;
            pc_nxt = ras_top;
          end else begin
            err_nxt = 1'b1;
          end
        end
        REQ_CALL: begin
          if (!ras_full) begin
            push   = 1'b1;
            pc_nxt = bus.jmp_addr;
          end else begin
            err_nxt = 1'b1;
          end
        end
        REQ_JMP:  pc_nxt = bus.jmp_addr;
        default:  pc_nxt = pc_inc;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q  <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_nxt;
      err_q <= err_nxt;
    end
  end

  assign bus.pc_out      = pc_q;
  assign bus.stack_empty = ras_empty;
  assign bus.stack_full  = ras_full;
  assign bus.stack_err   = err_q;
endmodule

// File: tb/tb_cpu_pc.sv
// Directed and random checks of cpu_pc against a queue-based reference model.
module tb_cpu_pc;
  localparam int W = 8;
  localparam int D = 4;

  logic clk;
  logic rst;
  int   checks;
  int   fails;

  logic [W-1:0] m_pc;
  logic [W-1:0] m_stack[$];
  logic         m_err;

  cpu_pc_if #(.WIDTH(W)) bus ();

  cpu_pc #(.WIDTH(W), .STACK_DEPTH(D)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock with the given requests; model updated from the rules, outputs compared 1ns later.
  task automatic step(input logic r, input logic e, input logic j, input logic c,
                      input logic rt, input logic [W-1:0] a);
    rst = r; bus.en = e; bus.jmp = j; bus.call = c; bus.ret = rt; bus.jmp_addr = a;
    @(posedge clk);
    if (r) begin
      m_pc = '0;
      m_stack.delete();
      m_err = 1'b0;
    end else if (e) begin
      if (rt) begin
        if (m_stack.size() > 0) m_pc = m_stack.pop_back();
        else begin m_pc = m_pc + 1'b1; m_err = 1'b1; end
      end else if (c) begin
        if (m_stack.size() < D) begin m_stack.push_back(m_pc + 1'b1); m_pc = a; end
        else begin m_pc = m_pc + 1'b1; m_err = 1'b1; end
      end else if (j) begin
        m_pc = a;
      end else begin
        m_pc = m_pc + 1'b1;
      end
    end
    #1;
    check("pc",    bus.pc_out,              m_pc);
    check("empty", W'(bus.stack_empty),     W'(m_stack.size() == 0));
    check("full",  W'(bus.stack_full),      W'(m_stack.size() == D));
    check("err",   W'(bus.stack_err),       W'(m_err));
  endtask

  initial begin
    checks = 0; fails = 0;
    m_pc = '0; m_err = 1'b0;
    rst = 1'b1; bus.en = 1'b0; bus.jmp = 1'b0; bus.call = 1'b0; bus.ret = 1'b0; bus.jmp_addr = '0;

    // Reset then count, then freeze
    step(1, 1, 0, 1, 0, 8'd33);
    check("rst_pc", bus.pc_out, 8'd0);
    repeat (3) step(0, 1, 0, 0, 0, 8'd0);
    check("count3", bus.pc_out, 8'd3);
    step(0, 0, 1, 0, 0, 8'd99);
    step(0, 0, 0, 1, 1, 8'd99);
    check("hold", bus.pc_out, 8'd3);

    // Wrap from all-ones
    step(0, 1, 1, 0, 0, 8'hFF);
    step(0, 1, 0, 0, 0, 8'd0);
    check("wrap", bus.pc_out, 8'h00);

    // Simple call/return
    step(1, 1, 0, 0, 0, 8'd0);
    step(0, 1, 1, 0, 0, 8'd5);
    step(0, 1, 0, 1, 0, 8'd40);
    check("call_pc", bus.pc_out, 8'd40);
    repeat (2) step(0, 1, 0, 0, 0, 8'd0);
    step(0, 1, 0, 0, 1, 8'd0);
    check("ret_pc", bus.pc_out, 8'd6);

    // Fill, overflow, drain
    step(1, 1, 0, 0, 0, 8'd0);
    step(0, 1, 0, 1, 0, 8'd10);
    step(0, 1, 0, 1, 0, 8'd20);
    step(0, 1, 0, 1, 0, 8'd30);
    step(0, 1, 0, 1, 0, 8'd40);
    step(0, 1, 0, 1, 0, 8'd90);
    check("ovf_pc", bus.pc_out, 8'd41);
    repeat (4) step(0, 1, 0, 0, 1, 8'd0);
    check("drain_last", bus.pc_out, 8'd1);

    // Underflow, then all three requests at once
    step(1, 1, 0, 0, 0, 8'd0);
    step(0, 1, 1, 0, 0, 8'd10);
    step(0, 1, 0, 0, 1, 8'd0);
    check("unf_pc", bus.pc_out, 8'd11);
    step(1, 1, 0, 0, 0, 8'd0);
    step(0, 1, 1, 0, 0, 8'd19);
    step(0, 1, 0, 1, 0, 8'd50);
    step(0, 1, 1, 1, 1, 8'd77);
    check("prio_pc", bus.pc_out, 8'd20);

    // Reset wins over a call with two entries stacked
    step(0, 1, 0, 1, 0, 8'd5);
    step(0, 1, 0, 1, 0, 8'd9);
    step(0, 1, 0, 0, 1, 8'd0);
    step(0, 1, 0, 0, 1, 8'd0);
    step(0, 1, 0, 1, 0, 8'd60);
    step(0, 1, 0, 1, 0, 8'd70);
    step(1, 1, 0, 1, 0, 8'd80);
    check("rst_call_pc", bus.pc_out, 8'd0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 49) == 0),
           ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) == 0),
           W'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/cpu_pc.md
CPU_PC -- requirements
Module: cpu_pc

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the program-address width.
REQ-002 SHALL have parameter STACK_DEPTH, default 4, the number of return-address stack entries (power of two, at least 2).
REQ-003 CLK  input  1  the single clock; all state updates on its rising edge.
REQ-004 RST  input  1  reset, synchronous and active-high.
REQ-005 EN  input  1  advance enable; 0 freezes all state.
REQ-006 JMP  input  1  jump request; load JMP_ADDR into the PC.
REQ-007 JMP_ADDR  input  WIDTH  target address from the jump-address unit.
REQ-008 CALL  input  1  call request; push the return address, then jump to JMP_ADDR.
REQ-009 RET  input  1  return request; pop the stack top into the PC.
REQ-010 PC_OUT  output  WIDTH  current program counter, registered.
REQ-011 STACK_EMPTY  output  1  high when the stack holds 0 entries.
REQ-012 STACK_FULL  output  1  high when the stack holds STACK_DEPTH entries.
REQ-013 STACK_ERR  output  1  sticky overflow/underflow flag.

Function
REQ-014 SHALL sample all requests on the rising CLK edge; the new PC_OUT SHALL be visible after that edge (1-cycle latency, no combinational input-to-PC_OUT path).
REQ-015 With EN=0, PC, stack, count and STACK_ERR SHALL hold; requests are ignored.
REQ-016 With EN=1 and no request, PC SHALL become PC+1 modulo 2^WIDTH (all-ones wraps to 0).
REQ-017 Simultaneous requests SHALL resolve with priority RET > CALL > JMP; lower-priority requests are discarded.
REQ-018 JMP SHALL load PC := JMP_ADDR and leave the stack unchanged.
REQ-019 CALL when not full SHALL push (PC+1) mod 2^WIDTH, load PC := JMP_ADDR, and increment the count.
REQ-020 CALL when full SHALL NOT push or jump; PC SHALL become PC+1, and STACK_ERR SHALL set.
REQ-021 RET when not empty SHALL load PC := the stack top and decrement the count.
REQ-022 RET when empty SHALL NOT change the stack; PC SHALL become PC+1, and STACK_ERR SHALL set.
REQ-023 The stack SHALL be LIFO; the count SHALL range from 0 to STACK_DEPTH inclusive.
REQ-024 STACK_EMPTY and STACK_FULL SHALL be decoded from the registered count, so they are valid in the same cycle as PC_OUT.
REQ-025 STACK_ERR SHALL clear only on RST.

Reset
REQ-026 RST=1 at a clock edge SHALL set PC_OUT=0, count=0 (STACK_EMPTY=1, STACK_FULL=0) and STACK_ERR=0; RST overrides EN and all requests.
REQ-027 Stack entry contents need not be reset; RST mid-sequence SHALL discard all pending return addresses.

Structure
REQ-028 The request priority encoding and the default STACK_DEPTH SHALL live in the shared CPU constants package; WIDTH remains a module parameter.
REQ-029 The return-address stack SHALL be a sub-module named cpu_ras (ports: push, pop, data in, top out, empty, full).
REQ-030 The PC increment SHALL reuse the existing alu_add adder with carry-in 1 and carry-out unused.

Verification
REQ-031 Reset then 3 cycles with EN=1 -> PC_OUT 0,1,2,3; then EN=0 for 2 cycles -> PC_OUT holds at 3.
REQ-032 PC=8'hFF, EN=1, no request -> PC_OUT=8'h00, STACK_ERR=0.
REQ-033 At PC=5, CALL with JMP_ADDR=40 -> PC=40, STACK_EMPTY=0; at PC=42, RET -> PC=6, STACK_EMPTY=1.
REQ-034 Four nested CALLs -> STACK_FULL=1; a fifth CALL at PC=p -> PC=p+1, STACK_ERR=1, stack unchanged; four RETs return the addresses in reverse order.
REQ-035 RET while empty at PC=10 -> PC=11, STACK_ERR=1; JMP+CALL+RET together with one stack entry 20 -> PC=20 (RET wins).
REQ-036 RST asserted together with CALL while stack count is 2 -> PC=0, STACK_EMPTY=1, STACK_ERR=0.
